cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
// - Memory-side counterpart of the 4-set direct-mapped data cache.
// - On a load miss it fetches the missing 16-byte line from data memory as four 32-bit word reads.
// - It presents the line to the cache as d0..d3 with a one-cycle fill strobe, and stalls the core until the fill lands.
// - It sits between the cache miss path and the main data memory port.
// PARAMETERS
// - DATA_WIDTH  32  word width and address width.
// - WORDS       4   words per line. Fixed at 4; any other value is illegal and must fail elaboration.
// PORTS
// - clk         in   1   rising-edge clock.
// - rst         in   1   synchronous, active-high reset.
// - MemRead     in   1   core load access valid this cycle.
// - A           in   32  core byte address.
// - Hit         in   1   cache tag match for A.
// - Stall       out  1   freeze core/PC.
// - mem_req     out  1   memory read request.
// - mem_addr    out  32  word-aligned read address.
// - mem_ack     in   1   memory returns mem_rdata this cycle.
// - mem_rdata   in   32  read data.
// - d0..d3      out  32  each; line words, d0 = lowest address.
// - fill_we     out  1   one-cycle write strobe into the cache set selected by A[5:4].
// - busy        out  1   state != IDLE.
// BEHAVIOUR
// - Reset values: state=IDLE; mem_req=0; mem_addr=0; d0..d3=0; fill_we=0; busy=0; idx=0.
// - FSM states and transitions:
//   - IDLE -> FETCH when MemRead & ~Hit. Latch base={A[31:4],4'b0}; latch idx=0.
//   - FETCH: mem_req=1; mem_addr=base+{idx,2'b00}.
//     - On a posedge with mem_req & mem_ack, mem_rdata is written to d[idx] and idx=idx+1 (mod 4).
//     - On the 4th ack, go to FILL.
//     - mem_req stays high between words. mem_addr advances in the cycle after each ack.
//   - FILL: fill_we=1 for exactly one cycle; d0..d3 are stable; mem_req=0. Next state is IDLE.
// - Stall (combinational) = (state!=IDLE) | (state==IDLE & MemRead & ~Hit). It deasserts in the cycle after FILL.
//   - In that cycle the cache hits and the core proceeds.
// - Latency with a zero-wait memory (mem_ack high whenever mem_req is high):
//   - miss seen at cycle 0; FETCH cycles 1-4; FILL cycle 5; IDLE cycle 6.
//   - 6 stall cycles in total.
// - Memory wait states extend FETCH one cycle per cycle without ack.
// - Boundary conditions:
//   - mem_ack while mem_req=0 is ignored.
//   - MemRead, Hit and A are ignored while busy; the base is not relatched.
//   - The core must hold A stable while Stall is high.
//   - A miss in the cycle right after FILL starts a new fetch with no idle gap.
//   - A Hit in IDLE does nothing.
//   - rst in any state forces reset values next cycle.
//     - A partial line is discarded and fill_we is never asserted for it.
//     - An ack arriving in the rst cycle is dropped.
//   - The address offset A[3:0] is ignored for the base. mem_addr[1:0] is always 00.
//   - base+offset never carries out of A[31:4].
// CONFIGURATION
// - REFILL_CRITICAL_WORD_FIRST_EN defined:
//   - idx starts at A[3:2] and wraps 3->0; exactly 4 words are fetched.
//   - d0..d3 remain positional, with d[k] written from base+4k.
//   - Stall drops one cycle after FILL, the same as the default mode.
// - REFILL_CRITICAL_WORD_FIRST_EN undefined: idx always starts at 0; fetch order is 0,1,2,3.
// TESTING
// - Miss at A=0x0000_0044 with zero-wait memory returning addr^0xA5A5_0000:
//   - mem_addr sequence is 0x40, 0x44, 0x48, 0x4C.
//   - fill_we is high in cycle 5 only; d1=0xA5A5_0044.
//   - Stall is high in cycles 0-5.
// - Same miss, mem_ack low for 2 cycles before each word:
//   - FILL at cycle 13; mem_addr holds across each wait.
// - MemRead=1, Hit=1 in IDLE -> Stall=0, mem_req=0, busy=0.
// - rst after 2 acks, then release:
//   - d0..d3=0, no fill_we pulse, mem_req=0.
//   - The next miss refetches from word 0.
// - With REFILL_CRITICAL_WORD_FIRST_EN and A=0x0000_0078:
//   - mem_addr sequence is 0x78, 0x7C, 0x70, 0x74.
//   - d2 holds the data for 0x78.
// - Back-to-back misses at 0x100 then 0x200:
//   - the second FETCH starts the cycle after the first FILL.
//   - each line has exactly one fill_we pulse.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//
// Memory-side refill engine for the 4-set direct-mapped data cache. On a load
// miss it reads the 16-byte line containing A from data memory as four word
// reads. It holds the words in d0..d3 and pulses fill_we for one cycle so the
// cache can write the line. Stall freezes the core until the fill has landed.
//
// Optional feature (compile-time macro REFILL_CRITICAL_WORD_FIRST_EN):
//   Defined   : the fetch starts at the word addressed by A[3:2] and wraps.
//               d0..d3 stay positional (d[k] always comes from base+4k).
//   Undefined : the fetch order is always word 0,1,2,3.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   MemRead    in   core load access valid this cycle
//   A          in   core byte address (must be held stable while Stall is high)
//   Hit        in   cache tag match for A
//   Stall      out  freeze core/PC (combinational)
//   mem_req    out  memory read request
//   mem_addr   out  word-aligned memory read address
//   mem_ack    in   mem_rdata is valid this cycle
//   mem_rdata  in   memory read data
//   d0..d3     out  line words, d0 = lowest address
//   fill_we    out  one-cycle write strobe into the set selected by A[5:4]
//   busy       out  refill in progress (state != IDLE)
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  Hit,
  output logic                  Stall,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] d3,
  output logic                  fill_we,
  output logic                  busy
);

  // The line layout (two index bits, 16-byte line) is hard-wired below.
  if (WORDS != 4) begin : g_words_check
    $error("cache_refill_ctrl: WORDS must be 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-5:0]   base_line;   // A[31:4] of the missing line
  logic [1:0]              idx;         // word currently being fetched
  logic [1:0]              ack_cnt;     // words received so far
  logic [1:0]              start_idx;
  logic [DATA_WIDTH-1:0]   line_q [WORDS];
  logic                    miss;

  assign miss = MemRead & ~Hit;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = A[3:2];
  logic unused_a_ofs;
  assign unused_a_ofs = ^A[1:0];
`else
  assign start_idx = 2'b00;
  logic unused_a_ofs;
  assign unused_a_ofs = ^A[3:0];
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    fill_we   = 1'b0;
    busy      = (state != IDLE);
    Stall     = (state != IDLE) | miss;
    unique case (state)
      IDLE: begin
        if (miss) state_nxt = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack && ack_cnt == 2'd3) state_nxt = FILL;
      end
      FILL: begin
        fill_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: base/index capture and line buffer
  // ---------------------------------------------------------------------------
  // NOTE: the line buffer is only four words and its contents are visible on
  // d0..d3, so it is reset explicitly; a discarded partial line must read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_line <= '0;
      idx       <= '0;
      ack_cnt   <= '0;
      for (int k = 0; k < WORDS; k++) line_q[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Inputs are only sampled here; while busy the base is never relatched.
          if (miss) begin
            base_line <= A[DATA_WIDTH-1:4];
            idx       <= start_idx;
            ack_cnt   <= '0;
          end
        end
        FETCH: begin
          // mem_req is high throughout FETCH, so mem_ack alone qualifies a word.
          if (mem_ack) begin
            line_q[idx] <= mem_rdata;
            idx         <= idx + 2'd1;
            ack_cnt     <= ack_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The word offset is concatenated rather than added: it can never carry
  // into the line address, and the byte offset is always zero.
  assign mem_addr = {base_line, idx, 2'b00};

  assign d0 = line_q[0];
  assign d1 = line_q[1];
  assign d2 = line_q[2];
  assign d3 = line_q[3];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Directed bench for cache_refill_ctrl. The memory model answers any address
// with addr ^ 0xA5A5_0000; the bench decides on which cycles mem_ack is high.
// Inputs change 1 ns after a rising edge, outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

  localparam logic [31:0] PATTERN = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic [31:0] A;
  logic        Hit;
  logic        Stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] d0, d1, d2, d3;
  logic        fill_we;
  logic        busy;

  int tests_run;
  int tests_failed;

  cache_refill_ctrl #(.DATA_WIDTH(32), .WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .A         (A),
    .Hit       (Hit),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .fill_we   (fill_we),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory data is a pure function of the address.
  assign mem_rdata = mem_addr ^ PATTERN;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word index the refill starts at for address a.
  function automatic int first_word(input logic [31:0] a);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    return int'(a[3:2]);
`else
    return 0;
`endif
  endfunction

  // Full miss sequence. Called at the start of a cycle that is in IDLE; that
  // cycle is cycle 0. Each word is preceded by 'waits' cycles without ack.
  // With chain=1 the cycle after FILL is left to the caller (next miss).
  task automatic run_miss(input string tag, input logic [31:0] a,
                          input int waits, input bit chain);
    logic [31:0] base;
    logic [31:0] exp_addr;
    int          first;
    base  = {a[31:4], 4'h0};
    first = first_word(a);

    // cycle 0: miss seen in IDLE; an ack with no request must be ignored
    MemRead = 1'b1; Hit = 1'b0; A = a; mem_ack = 1'b1;
    #1;
    check({tag, " c0 Stall"},   32'(Stall),   32'd1);
    check({tag, " c0 busy"},    32'(busy),    32'd0);
    check({tag, " c0 mem_req"}, 32'(mem_req), 32'd0);

    for (int k = 0; k < 4; k++) begin
      exp_addr = base + 32'(((first + k) % 4) * 4);
      for (int w = 0; w <= waits; w++) begin
        tick();
        // Core-side inputs wiggle while busy; they must have no effect.
        MemRead = 1'b1;
        Hit     = w[0];
        A       = 32'hFFFF_FFF4;
        mem_ack = (w == waits);
        #1;
        check($sformatf("%s w%0d.%0d mem_req", tag, k, w),  32'(mem_req), 32'd1);
        check($sformatf("%s w%0d.%0d mem_addr", tag, k, w), mem_addr,     exp_addr);
        check($sformatf("%s w%0d.%0d fill_we", tag, k, w),  32'(fill_we), 32'd0);
        check($sformatf("%s w%0d.%0d Stall", tag, k, w),    32'(Stall),   32'd1);
      end
    end

    // FILL cycle
    tick();
    MemRead = 1'b1; Hit = 1'b0; A = a; mem_ack = 1'b1;
    #1;
    check({tag, " fill fill_we"}, 32'(fill_we), 32'd1);
    check({tag, " fill mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " fill Stall"},   32'(Stall),   32'd1);
    check({tag, " fill d0"}, d0, (base + 32'h0) ^ PATTERN);
    check({tag, " fill d1"}, d1, (base + 32'h4) ^ PATTERN);
    check({tag, " fill d2"}, d2, (base + 32'h8) ^ PATTERN);
    check({tag, " fill d3"}, d3, (base + 32'hC) ^ PATTERN);

    // Cycle after FILL: back in IDLE, strobe gone.
    tick();
    mem_ack = 1'b0;
    if (!chain) begin
      MemRead = 1'b1; Hit = 1'b1; A = a;
      #1;
      check({tag, " post fill_we"}, 32'(fill_we), 32'd0);
      check({tag, " post Stall"},   32'(Stall),   32'd0);
      check({tag, " post busy"},    32'(busy),    32'd0);
      check({tag, " post mem_req"}, 32'(mem_req), 32'd0);
      // Line is held after the fill.
      check({tag, " post d1"}, d1, (base + 32'h4) ^ PATTERN);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    MemRead = 1'b0;
    Hit     = 1'b0;
    A       = 32'h0;
    mem_ack = 1'b0;
    tick();
    tick();

    // ---------------- reset state ----------------
    rst = 1'b0;
    #1;
    check("reset busy",     32'(busy),    32'd0);
    check("reset mem_req",  32'(mem_req), 32'd0);
    check("reset mem_addr", mem_addr,     32'h0);
    check("reset fill_we",  32'(fill_we), 32'd0);
    check("reset Stall",    32'(Stall),   32'd0);
    check("reset d0",       d0,           32'h0);
    check("reset d3",       d3,           32'h0);

    // ---------------- hit in IDLE does nothing ----------------
    tick();
    MemRead = 1'b1; Hit = 1'b1; A = 32'h0000_0044; mem_ack = 1'b1;
    #1;
    check("hit Stall",   32'(Stall),   32'd0);
    check("hit mem_req", 32'(mem_req), 32'd0);
    tick();
    #1;
    check("hit busy next",    32'(busy),    32'd0);
    check("hit fill_we next", 32'(fill_we), 32'd0);
    check("hit d0 next",      d0,           32'h0);

    // ---------------- zero-wait miss at 0x44 ----------------
    run_miss("zw44", 32'h0000_0044, 0, 1'b0);

    // ---------------- two wait states per word (FILL at cycle 13) ----------------
    tick();
    run_miss("ws84", 32'h0000_0084, 2, 1'b0);

    // ---------------- reset after two acks ----------------
    tick();
    MemRead = 1'b1; Hit = 1'b0; A = 32'h0000_0104; mem_ack = 1'b0;
    tick();
    MemRead = 1'b0; mem_ack = 1'b1;                 // ack #1
    tick();                                          // ack #2
    tick();
    rst = 1'b1;                                      // ack in the rst cycle is dropped
    tick();
    rst = 1'b0; mem_ack = 1'b0; MemRead = 1'b0;
    #1;
    check("rst busy",     32'(busy),    32'd0);
    check("rst mem_req",  32'(mem_req), 32'd0);
    check("rst mem_addr", mem_addr,     32'h0);
    check("rst fill_we",  32'(fill_we), 32'd0);
    check("rst d0",       d0,           32'h0);
    check("rst d1",       d1,           32'h0);
    check("rst d2",       d2,           32'h0);
    check("rst d3",       d3,           32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check($sformatf("rst idle%0d fill_we", i), 32'(fill_we), 32'd0);
    end
    // Next miss refetches the line from its first word.
    tick();
    run_miss("rst refetch", 32'h0000_010C, 0, 1'b0);

    // ---------------- critical-word address (0x78) ----------------
    tick();
    run_miss("cw78", 32'h0000_0078, 0, 1'b0);

    // ---------------- back-to-back misses, high address bits ----------------
    tick();
    run_miss("b2b 100", 32'h0000_0100, 0, 1'b1);
    run_miss("b2b 200", 32'h0000_0200, 1, 1'b1);
    run_miss("b2b hi",  32'hFFFF_FFF8, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
